// File: rtl/pfs_pkg.sv
// Shared constants and types for the c2 parallel-fault simulation engine.
// Holds the fault count, the net numbering of the c2 netlist and the FSM state type.
// A fault number is 2*net + polarity, where polarity 0 is stuck-at-0 and 1 is stuck-at-1.
package pfs_pkg;

  localparam int NUM_FAULTS = 34;
  localparam int NUM_NETS   = 17;

  // Net numbering in topological order
  localparam int NET_A  = 0;
  localparam int NET_B  = 1;
  localparam int NET_C  = 2;
  localparam int NET_D  = 3;
  localparam int NET_E  = 4;
  localparam int NET_X  = 5;
  localparam int NET_X1 = 6;
  localparam int NET_X2 = 7;
  localparam int NET_E1 = 8;
  localparam int NET_E2 = 9;
  localparam int NET_W1 = 10;
  localparam int NET_W2 = 11;
  localparam int NET_Y  = 12;
  localparam int NET_Y1 = 13;
  localparam int NET_Y2 = 14;
  localparam int NET_F1 = 15;
  localparam int NET_F2 = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/pfs_c2_eval.sv
// Bit-parallel evaluator for the c2 netlist, with stuck-at masks applied on every net.
// Latency: purely combinational, so results are valid in the same cycle as the inputs.
// Backpressure: none. Lane 0 is the good machine and the other lanes are faulty machines.
module pfs_c2_eval
  import pfs_pkg::*;
#(
  parameter int LANES = 8
) (
  input  logic [4:0]                      i_pat,
  input  logic [NUM_NETS-1:0][LANES-1:0]  i_sa0,
  input  logic [NUM_NETS-1:0][LANES-1:0]  i_sa1,
  output logic [LANES-1:0]                o_f1,
  output logic [LANES-1:0]                o_f2
);

  // Force a net word to its stuck values: the sa0 mask clears lanes and the sa1 mask sets them
  function automatic logic [LANES-1:0] inj(input logic [LANES-1:0] v,
                                           input logic [LANES-1:0] m0,
                                           input logic [LANES-1:0] m1);
    return (v & ~m0) | m1;
  endfunction

  logic [LANES-1:0] w_a, w_b, w_c, w_d, w_e;
  logic [LANES-1:0] w_x, w_x1, w_x2, w_e1, w_e2;
  logic [LANES-1:0] w_w1, w_w2, w_y, w_y1, w_y2;
  logic [LANES-1:0] w_f1, w_f2;

  // Broadcast the pattern to every lane; a is the MSB
  assign w_a  = inj({LANES{i_pat[4]}}, i_sa0[NET_A], i_sa1[NET_A]);
  assign w_b  = inj({LANES{i_pat[3]}}, i_sa0[NET_B], i_sa1[NET_B]);
  assign w_c  = inj({LANES{i_pat[2]}}, i_sa0[NET_C], i_sa1[NET_C]);
  assign w_d  = inj({LANES{i_pat[1]}}, i_sa0[NET_D], i_sa1[NET_D]);
  assign w_e  = inj({LANES{i_pat[0]}}, i_sa0[NET_E], i_sa1[NET_E]);

  // Stems and fanout branches get their own masks so branch faults stay distinct from stem faults
  assign w_x  = inj(~(w_b & w_c),      i_sa0[NET_X],  i_sa1[NET_X]);
  assign w_x1 = inj(w_x,               i_sa0[NET_X1], i_sa1[NET_X1]);
  assign w_x2 = inj(w_x,               i_sa0[NET_X2], i_sa1[NET_X2]);
  assign w_e1 = inj(w_e,               i_sa0[NET_E1], i_sa1[NET_E1]);
  assign w_e2 = inj(w_e,               i_sa0[NET_E2], i_sa1[NET_E2]);
  assign w_w1 = inj(~(w_d ^ w_e1),     i_sa0[NET_W1], i_sa1[NET_W1]);
  assign w_w2 = inj(w_a | w_x1,        i_sa0[NET_W2], i_sa1[NET_W2]);
  assign w_y  = inj(w_w1 & w_x2,       i_sa0[NET_Y],  i_sa1[NET_Y]);
  assign w_y1 = inj(w_y,               i_sa0[NET_Y1], i_sa1[NET_Y1]);
  assign w_y2 = inj(w_y,               i_sa0[NET_Y2], i_sa1[NET_Y2]);
  assign w_f1 = inj(w_w2 & w_y1,       i_sa0[NET_F1], i_sa1[NET_F1]);
  assign w_f2 = inj(w_y2 ^ w_e2,       i_sa0[NET_F2], i_sa1[NET_F2]);

  assign o_f1 = w_f1;
  assign o_f2 = w_f2;

endmodule

// File: rtl/pfs_c2_engine.sv
// Parallel-fault simulator for c2: simulates one fault group per cycle and keeps a sticky detection bitmap.
// Latency: a handshake at edge N gives done_o in cycle N+G+1, where G = ceil(34/(LANES-1)).
// Backpressure: pat_ready_o is high only in IDLE. Defining PFS_FAULT_DROP_EN skips groups that are already fully detected.
module pfs_c2_engine
  import pfs_pkg::*;
#(
  parameter int LANES = 8   // legal range 2..35
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [4:0]             pat_i,
  input  logic                   pat_valid_i,
  output logic                   pat_ready_o,
  input  logic                   clear_i,
  output logic [NUM_FAULTS-1:0]  det_map_o,
  output logic [5:0]             det_cnt_o,
  output logic                   done_o
);

  localparam int LPG = LANES - 1;                          // faulty lanes per group
  localparam int G   = (NUM_FAULTS + LPG - 1) / LPG;       // number of groups

  state_t                        r_state, w_state_nxt;
  logic [4:0]                    r_pat;
  logic [5:0]                    r_grp, w_grp_nxt;
  logic [NUM_FAULTS-1:0]         r_map, w_new_det, w_map_acc;
  logic [NUM_NETS-1:0][LANES-1:0] w_sa0, w_sa1;
  logic [LANES-1:0]              w_f1, w_f2;
  logic [LANES-1:1]              w_diff;
  logic                          w_ld, w_clr, w_acc;
  logic                          w_more;
  logic [5:0]                    w_grp_skip;

  pfs_c2_eval #(.LANES(LANES)) u_eval (
    .i_pat (r_pat),
    .i_sa0 (w_sa0),
    .i_sa1 (w_sa1),
    .o_f1  (w_f1),
    .o_f2  (w_f2)
  );

  // Fault f belongs to group f/LPG and sits on lane f%LPG+1; build the masks for the current group
  always_comb begin
    w_sa0 = '0;
    w_sa1 = '0;
    for (int f = 0; f < NUM_FAULTS; f++) begin
      if (r_grp == 6'(f / LPG)) begin
        if (f % 2 == 1) w_sa1[f / 2][f % LPG + 1] = 1'b1;
        else            w_sa0[f / 2][f % LPG + 1] = 1'b1;
      end
    end
  end

  // A faulty lane is detected when either output disagrees with the good lane
  assign w_diff = (w_f1[LANES-1:1] ^ {LPG{w_f1[0]}}) | (w_f2[LANES-1:1] ^ {LPG{w_f2[0]}});

  // Map lane detections of the current group back onto fault numbers
  always_comb begin
    w_new_det = '0;
    for (int f = 0; f < NUM_FAULTS; f++) begin
      if (r_grp == 6'(f / LPG)) w_new_det[f] = w_diff[f % LPG + 1];
    end
  end

  assign w_map_acc = r_map | w_new_det;

`ifdef PFS_FAULT_DROP_EN
  logic [G-1:0] w_grp_open;

  // A group still needs work while any of its faults is undetected, counting this cycle's detections
  always_comb begin
    w_grp_open = '0;
    for (int f = 0; f < NUM_FAULTS; f++) begin
      w_grp_open[f / LPG] = w_grp_open[f / LPG] | ~w_map_acc[f];
    end
  end

  // Jump to the lowest open group after the current one; none left means the pattern is finished
  always_comb begin
    w_more     = 1'b0;
    w_grp_skip = r_grp;
    for (int g = G - 1; g >= 0; g--) begin
      if ((6'(g) > r_grp) && w_grp_open[g]) begin
        w_more     = 1'b1;
        w_grp_skip = 6'(g);
      end
    end
  end
`else
  // Walk every group in order
  always_comb begin
    w_more     = (r_grp != 6'(G - 1));
    w_grp_skip = r_grp + 6'd1;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // FSM next state, datapath controls and handshake/done outputs
  always_comb begin
    w_state_nxt = r_state;
    w_grp_nxt   = r_grp;
    w_ld        = 1'b0;
    w_clr       = 1'b0;
    w_acc       = 1'b0;
    pat_ready_o = 1'b0;
    done_o      = 1'b0;
    case (r_state)
      IDLE: begin
        pat_ready_o = 1'b1;
        w_clr       = clear_i;
        if (pat_valid_i) begin
          w_ld        = 1'b1;
          w_grp_nxt   = '0;
          w_state_nxt = EVAL;
        end
      end
      EVAL: begin
        w_acc = 1'b1;
        if (w_more) begin
          w_grp_nxt = w_grp_skip;
        end else begin
          w_grp_nxt   = '0;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        done_o      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Pattern latch, group counter and sticky bitmap; clear only happens in IDLE so it never meets accumulate
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pat <= '0;
      r_grp <= '0;
      r_map <= '0;
    end else begin
      r_grp <= w_grp_nxt;
      if (w_ld) r_pat <= pat_i;
      if (w_clr)      r_map <= '0;
      else if (w_acc) r_map <= w_map_acc;
    end
  end

  assign det_map_o = r_map;

  // Popcount of the bitmap
  always_comb begin
    det_cnt_o = '0;
    for (int i = 0; i < NUM_FAULTS; i++) det_cnt_o = det_cnt_o + 6'(r_map[i]);
  end

endmodule

// File: tb/tb_pfs_c2_engine.sv
module tb_pfs_c2_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  pat_i;
  logic        pat_valid_i;
  logic        clear_i;
  logic        rdy8, rdy35, done8, done35;
  logic [33:0] map8, map35;
  logic [5:0]  cnt8, cnt35;

  int checks = 0;
  int errors = 0;

  localparam logic [33:0] MAP_00000 = 34'h1_555A_5680;  // 14 faults
  localparam logic [33:0] MAP_01100 = 34'h2_A208_8A14;  // 10 faults
  localparam logic [33:0] MAP_11111 = 34'h1_AA04_8914;  // 11 faults
  localparam logic [33:0] MAP_U0    = 34'h3_F75A_DE94;  // 00000 then 01100, 22 faults

  always #5 clk = ~clk;

  pfs_c2_engine #(.LANES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .pat_i(pat_i), .pat_valid_i(pat_valid_i),
    .pat_ready_o(rdy8), .clear_i(clear_i), .det_map_o(map8),
    .det_cnt_o(cnt8), .done_o(done8)
  );

  pfs_c2_engine #(.LANES(35)) u_dut35 (
    .clk(clk), .rst_n(rst_n), .pat_i(pat_i), .pat_valid_i(pat_valid_i),
    .pat_ready_o(rdy35), .clear_i(clear_i), .det_map_o(map35),
    .det_cnt_o(cnt35), .done_o(done35)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scalar single-fault reference for c2; flt < 0 means the good machine
  function automatic logic inj(input int flt, input int n, input logic v);
    if (flt >= 0 && flt / 2 == n) return (flt % 2 == 1);
    return v;
  endfunction

  function automatic logic [1:0] sim(input logic [4:0] p, input int flt);
    logic v [17];
    v[0]  = inj(flt, 0, p[4]);
    v[1]  = inj(flt, 1, p[3]);
    v[2]  = inj(flt, 2, p[2]);
    v[3]  = inj(flt, 3, p[1]);
    v[4]  = inj(flt, 4, p[0]);
    v[5]  = inj(flt, 5, ~(v[1] & v[2]));
    v[6]  = inj(flt, 6, v[5]);
    v[7]  = inj(flt, 7, v[5]);
    v[8]  = inj(flt, 8, v[4]);
    v[9]  = inj(flt, 9, v[4]);
    v[10] = inj(flt, 10, ~(v[3] ^ v[8]));
    v[11] = inj(flt, 11, v[0] | v[6]);
    v[12] = inj(flt, 12, v[10] & v[7]);
    v[13] = inj(flt, 13, v[12]);
    v[14] = inj(flt, 14, v[12]);
    v[15] = inj(flt, 15, v[11] & v[13]);
    v[16] = inj(flt, 16, v[14] ^ v[9]);
    return {v[15], v[16]};
  endfunction

  function automatic logic [33:0] model_det(input logic [4:0] p);
    logic [33:0] d = '0;
    logic [1:0]  good = sim(p, -1);
    for (int f = 0; f < 34; f++) d[f] = (sim(p, f) != good);
    return d;
  endfunction

  // Entered and left #1 after a rising edge with both engines idle.
  // clr is presented with the handshake; mid is presented during the first EVAL cycle only.
  task automatic run_pat(input logic [4:0] p, input logic clr, input logic mid);
    int lat8 = -1, lat35 = -1, pulses8 = 0;
    logic rdy_eval = 1'b1;
    pat_i = p; pat_valid_i = 1'b1; clear_i = clr;
    @(posedge clk); #1;
    pat_valid_i = 1'b0; clear_i = mid;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      clear_i = 1'b0;
      if (c == 1) rdy_eval = rdy8;
      if (done8) pulses8++;
      if (done8 && lat8 < 0) lat8 = c;
      if (done35 && lat35 < 0) lat35 = c;
    end
    chk("ready_low_in_eval", 64'(rdy_eval), 64'd0);
    chk("done8_pulse_width", 64'(pulses8), 64'd1);
`ifdef PFS_FAULT_DROP_EN
    chk("lat8_bounded", 64'(lat8 >= 1 && lat8 <= 5), 64'd1);
`else
    chk("lat8_edges_to_done", 64'(lat8), 64'd5);
`endif
    chk("lat35_edges_to_done", 64'(lat35), 64'd1);
  endtask

  initial begin
    logic [33:0] exp_map;
    rst_n = 1'b0; pat_i = '0; pat_valid_i = 1'b0; clear_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_map8", 64'(map8), 64'd0);
    chk("rst_cnt8", 64'(cnt8), 64'd0);
    chk("rst_done8", 64'(done8), 64'd0);
    chk("rst_ready8", 64'(rdy8), 64'd1);
    chk("rst_ready35", 64'(rdy35), 64'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 00000: y sa0 (24) and f1 sa0 (30) among 14 detections
    run_pat(5'b00000, 1'b0, 1'b0);
    chk("p00000_map8", 64'(map8), 64'(MAP_00000));
    chk("p00000_cnt8", 64'(cnt8), 64'd14);
    chk("p00000_bit24", 64'(map8[24]), 64'd1);
    chk("p00000_bit30", 64'(map8[30]), 64'd1);
    chk("p00000_map35", 64'(map35), 64'(MAP_00000));

    // 01100 accumulates onto the previous pattern
    run_pat(5'b01100, 1'b0, 1'b0);
    chk("acc_map8", 64'(map8), 64'(MAP_U0));
    chk("acc_cnt8", 64'(cnt8), 64'd22);
    chk("acc_bit11", 64'(map8[11]), 64'd1);
    chk("acc_map35", 64'(map35), 64'(MAP_U0));

    // clear together with handshake keeps only the new pattern
    run_pat(5'b01100, 1'b1, 1'b0);
    chk("clrhs_map8", 64'(map8), 64'(MAP_01100));
    chk("clrhs_cnt8", 64'(cnt8), 64'd10);
    chk("clrhs_cnt35", 64'(cnt35), 64'd10);

    // clear alone in IDLE
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk("clr_idle_map8", 64'(map8), 64'd0);
    chk("clr_idle_cnt8", 64'(cnt8), 64'd0);

    // clear during EVAL is ignored
    run_pat(5'b00000, 1'b0, 1'b1);
    chk("clr_eval_map8", 64'(map8), 64'(MAP_00000));
    chk("clr_eval_map35", 64'(map35), 64'(MAP_00000));

    run_pat(5'b11111, 1'b1, 1'b0);
    chk("p11111_map8", 64'(map8), 64'(MAP_11111));
    chk("p11111_cnt8", 64'(cnt8), 64'd11);
    chk("p11111_map35", 64'(map35), 64'(MAP_11111));

    // reset in the second EVAL cycle
    pat_i = 5'b01100; pat_valid_i = 1'b1;
    @(posedge clk); #1;
    pat_valid_i = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_map8", 64'(map8), 64'd0);
    chk("midrst_cnt8", 64'(cnt8), 64'd0);
    chk("midrst_done8", 64'(done8), 64'd0);
    chk("midrst_ready8", 64'(rdy8), 64'd1);
    chk("midrst_map35", 64'(map35), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin
      @(posedge clk); #1;
      chk("midrst_no_resume", 64'({done8, rdy8}), 64'b01);
    end
    run_pat(5'b00000, 1'b0, 1'b0);
    chk("postrst_map8", 64'(map8), 64'(MAP_00000));

    // every pattern against the scalar reference, each starting from a cleared map
    for (int p = 0; p < 32; p++) begin
      exp_map = model_det(5'(p));
      run_pat(5'(p), 1'b1, 1'b0);
      chk($sformatf("model_map8_p%0d", p), 64'(map8), 64'(exp_map));
      chk($sformatf("model_map35_p%0d", p), 64'(map35), 64'(exp_map));
      chk($sformatf("model_cnt8_p%0d", p), 64'(cnt8), 64'($countones(exp_map)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
